// File: rtl/iterative_divider_if.sv
// Handshake and data bundle between a requester and iterative_divider.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             STALL;
  logic             START;
  logic             SIGN;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             BUSY;
  logic             DONE;

  modport master (
    output STALL, START, SIGN, DIVIDEND, DIVISOR,
    input  QUOTIENT, REMAINDER, BUSY, DONE
  );

  modport slave (
    input  STALL, START, SIGN, DIVIDEND, DIVISOR,
    output QUOTIENT, REMAINDER, BUSY, DONE
  );
endinterface

// File: rtl/iterative_divider.sv
// Restoring shift-subtract divider, signed/unsigned, BITS_PER_CYCLE quotient bits per cycle.
// Define DIV_EARLY_OUT_EN to resolve divide-by-zero and signed overflow at accept time.
module iterative_divider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                CLK,
  input logic                RSTN,
  iterative_divider_if.slave bus
);
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;

  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             dvz_q, dvz_d, ovf_q, ovf_d;

  logic             in_dvz, in_ovf, early;
  logic [WIDTH:0]   step_rem, step_diff;
  logic [WIDTH-1:0] step_acc;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] x);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  assign in_dvz = (bus.DIVISOR == '0);
  assign in_ovf = bus.SIGN && (bus.DIVIDEND == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.DIVISOR);

`ifdef DIV_EARLY_OUT_EN
  assign early = in_dvz || in_ovf;
`else
  assign early = 1'b0;
`endif

  // acc holds the unconsumed dividend bits in its MSBs and the retired quotient bits in its LSBs
  always_comb begin
    step_rem  = prem_q;
    step_acc  = acc_q;
    step_diff = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_rem  = {step_rem[WIDTH-1:0], step_acc[WIDTH-1]};
      step_acc  = {step_acc[WIDTH-2:0], 1'b0};
      step_diff = step_rem - {1'b0, dvsr_q};
      if (!step_diff[WIDTH]) begin
        step_rem    = step_diff;
        step_acc[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pend_d    = pend_q;
    quot_d    = quot_q;
    rmdr_d    = rmdr_q;
    prem_d    = prem_q;
    acc_d     = acc_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    ovf_d     = ovf_q;
    if (!bus.STALL) begin
      done_d = pend_q;
      pend_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            if (early) begin
              quot_d = in_dvz ? '1 : bus.DIVIDEND;
              rmdr_d = in_dvz ? bus.DIVIDEND : '0;
              pend_d = 1'b1;
            end else begin
              state_d   = CALC;
              cnt_d     = CNT_W'(N);
              prem_d    = '0;
              acc_d     = neg_if(bus.SIGN && bus.DIVIDEND[WIDTH-1], bus.DIVIDEND);
              dvsr_d    = neg_if(bus.SIGN && bus.DIVISOR[WIDTH-1], bus.DIVISOR);
              dvnd_d    = bus.DIVIDEND;
              neg_quo_d = bus.SIGN && (bus.DIVIDEND[WIDTH-1] ^ bus.DIVISOR[WIDTH-1]);
              neg_rem_d = bus.SIGN && bus.DIVIDEND[WIDTH-1];
              dvz_d     = in_dvz;
              ovf_d     = in_ovf;
            end
          end
        end
        CALC: begin
          prem_d = step_rem;
          acc_d  = step_acc;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
        FIX: begin
          if (dvz_q) begin
            quot_d = '1;
            rmdr_d = dvnd_q;
          end else if (ovf_q) begin
            quot_d = dvnd_q;
            rmdr_d = '0;
          end else begin
            quot_d = neg_if(neg_quo_q, acc_q);
            rmdr_d = neg_if(neg_rem_q, prem_q[WIDTH-1:0]);
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      quot_q  <= '0;
      rmdr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
    end
  end

  // Operand/working registers are only meaningful inside CALC/FIX, so they carry no reset
  always_ff @(posedge CLK) begin
    prem_q    <= prem_d;
    acc_q     <= acc_d;
    dvsr_q    <= dvsr_d;
    dvnd_q    <= dvnd_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dvz_q     <= dvz_d;
    ovf_q     <= ovf_d;
  end

  assign bus.QUOTIENT  = quot_q;
  assign bus.REMAINDER = rmdr_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = done_q;
endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per iteration (1, 2 or 4; divides WIDTH).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port STALL  input  1  freezes all state while high.
REQ-006 SHALL have port START  input  1  request; accepted when BUSY low and STALL low.
REQ-007 SHALL have port SIGN  input  1  1 = signed two's-complement, 0 = unsigned; sampled on accept.
REQ-008 SHALL have port DIVIDEND  input  WIDTH  numerator, sampled on accept.
REQ-009 SHALL have port DIVISOR  input  WIDTH  denominator, sampled on accept.
REQ-010 SHALL have port QUOTIENT  output  WIDTH  registered quotient.
REQ-011 SHALL have port REMAINDER  output  WIDTH  registered remainder.
REQ-012 SHALL have port BUSY  output  1  high while an operation is in flight.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse, results valid.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; BUSY = (state != IDLE).
REQ-015 On accept SHALL latch magnitudes of operands (negated when SIGN and MSB set), result-sign and remainder-sign flags, enter CALC with iteration counter N = WIDTH/BITS_PER_CYCLE.
REQ-016 CALC SHALL perform BITS_PER_CYCLE restoring shift-subtract steps per cycle on a WIDTH+1-bit partial remainder, decrement counter, go to FIX when counter reaches 1.
REQ-017 FIX SHALL negate quotient when dividend and divisor signs differ (signed only), negate remainder when dividend negative (remainder sign follows dividend), write QUOTIENT/REMAINDER, return to IDLE, assert DONE the following cycle.
REQ-018 Latency SHALL be N+1 edges from accepting edge to DONE high (WIDTH=32: 33 for BPC=1, 17 for BPC=2, 9 for BPC=4).
REQ-019 Divide by zero SHALL yield QUOTIENT = all ones, REMAINDER = DIVIDEND (signed and unsigned).
REQ-020 Signed overflow (DIVIDEND = 1 followed by zeros, DIVISOR = all ones, SIGN=1) SHALL yield QUOTIENT = DIVIDEND, REMAINDER = 0.
REQ-021 START while BUSY SHALL be ignored; no queuing.
REQ-022 START in the DONE cycle SHALL be accepted; DONE still deasserts next cycle.
REQ-023 STALL high SHALL hold state, counter, outputs and DONE unchanged; START ignored while stalled.
REQ-024 QUOTIENT/REMAINDER SHALL hold last result until the next FIX (or early-out) write; not altered by accept alone.

Reset
REQ-025 RSTN low SHALL immediately force IDLE, BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, counter=0, independent of CLK and STALL.
REQ-026 Reset mid-operation SHALL abandon the operation with no DONE; first accept after release behaves as from power-up.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow detected at accept, results written on accepting edge, FSM stays IDLE, DONE high next cycle (latency 1), BUSY never asserted.
REQ-028 Macro DIV_EARLY_OUT_EN undefined: those cases traverse CALC/FIX with normal latency N+1; FIX substitutes REQ-019/REQ-020 values.

Verification
REQ-029 WIDTH=32, BPC=1, SIGN=0, 100/7 -> QUOTIENT=14, REMAINDER=2, DONE exactly 33 cycles after accept, single pulse.
REQ-030 SIGN=1, 0xFFFFFFF9 / 2 (-7/2) -> QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF; 7 / 0xFFFFFFFE -> QUOTIENT=0xFFFFFFFD, REMAINDER=1.
REQ-031 SIGN=0, 5/0 -> QUOTIENT=0xFFFFFFFF, REMAINDER=5; DONE after 1 cycle with DIV_EARLY_OUT_EN, 33 without.
REQ-032 SIGN=1, 0x80000000 / 0xFFFFFFFF -> QUOTIENT=0x80000000, REMAINDER=0; SIGN=0 same operands -> QUOTIENT=0, REMAINDER=0x80000000.
REQ-033 STALL high 5 cycles during CALC -> DONE at cycle 38, results as unstalled; START pulsed while BUSY -> ignored, result unchanged.
REQ-034 RSTN low at cycle 10 of CALC -> BUSY=0, outputs 0 immediately, no DONE; BPC=4 run of 0xFFFFFFFF/3 afterwards -> QUOTIENT=0x55555555, REMAINDER=0, DONE at cycle 9.
